// File: rtl/ceespu_dmem_responder_if.sv
// CPU data-port and external SRAM signals of the ceespu data-memory responder.
// slave = responder view, master = CPU/SRAM-side driver view.
interface ceespu_dmem_responder_if;
  logic [15:0] I_dmemAddress;
  logic [31:0] I_dmemWData;
  logic        I_dmemE;
  logic [3:0]  I_dmemWe;
  logic [31:0] O_dmemData;
  logic        O_dmemBusy;
  logic        O_extReq;
  logic [12:0] O_extAddr;
  logic [31:0] O_extWData;
  logic [3:0]  O_extWe;
  logic        I_extAck;
  logic [31:0] I_extRData;
  logic        O_busError;

  modport slave (
    input  I_dmemAddress, I_dmemWData, I_dmemE, I_dmemWe, I_extAck, I_extRData,
    output O_dmemData, O_dmemBusy, O_extReq, O_extAddr, O_extWData, O_extWe, O_busError
  );

  modport master (
    output I_dmemAddress, I_dmemWData, I_dmemE, I_dmemWe, I_extAck, I_extRData,
    input  O_dmemData, O_dmemBusy, O_extReq, O_extAddr, O_extWData, O_extWe, O_busError
  );
endinterface

// File: rtl/ceespu_dmem_responder.sv
// Data-memory responder: internal RAM answers next cycle; external SRAM is a level request held until ack or timeout.
// Busy stalls the CPU only during external WAIT; requests arriving outside IDLE are ignored.
module ceespu_dmem_responder #(
  parameter int RAM_AW  = 12,
  parameter int TIMEOUT = 255
) (
  input logic I_clk,
  input logic I_rst,
  ceespu_dmem_responder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state, stateNext;
  logic [31:0] dmemData, dmemDataNext;
  logic        busy, busyNext;
  logic        extReq, extReqNext;
  logic [12:0] extAddr, extAddrNext;
  logic [31:0] extWData, extWDataNext;
  logic [3:0]  extWe, extWeNext;
  logic        busError, busErrorNext;
  logic [7:0]  count, countNext;

  logic [31:0] ram [2**RAM_AW];
  logic [RAM_AW-1:0] ramIdx;
  logic [31:0] ramRdWord;
  logic        ramWe;
  logic        unusedAddrBits;

  assign ramIdx         = bus.I_dmemAddress[RAM_AW+1:2];
  assign ramRdWord      = ram[ramIdx];
  assign unusedAddrBits = ^bus.I_dmemAddress[1:0];
  assign ramWe          = (state == IDLE) && bus.I_dmemE &&
                          (bus.I_dmemAddress[15:14] == 2'b00) && (bus.I_dmemWe != 4'b0000);

  always_comb begin
    stateNext    = state;
    dmemDataNext = dmemData;
    busyNext     = busy;
    extReqNext   = extReq;
    extAddrNext  = extAddr;
    extWDataNext = extWData;
    extWeNext    = extWe;
    busErrorNext = busError;
    countNext    = count;
    case (state)
      IDLE: begin
        if (bus.I_dmemE) begin
          if (bus.I_dmemAddress[15]) begin
            stateNext    = WAIT;
            extReqNext   = 1'b1;
            busyNext     = 1'b1;
            extAddrNext  = bus.I_dmemAddress[14:2];
            extWDataNext = bus.I_dmemWData;
            extWeNext    = bus.I_dmemWe;
            countNext    = 8'd0;
          end else if (!bus.I_dmemAddress[14]) begin
            // read-first: a write also returns the word as it was before this edge
            dmemDataNext = ramRdWord;
          end else if (bus.I_dmemWe == 4'b0000) begin
            dmemDataNext = 32'h0;
          end
        end
      end
      WAIT: begin
        countNext = count + 8'd1;
        // ack wins a tie with timeout, leaving the error flag untouched
        if (bus.I_extAck) begin
          stateNext  = RESP;
          extReqNext = 1'b0;
          busyNext   = 1'b0;
          if (extWe == 4'b0000) dmemDataNext = bus.I_extRData;
        end else if (count == TMO_LAST) begin
          stateNext    = RESP;
          extReqNext   = 1'b0;
          busyNext     = 1'b0;
          busErrorNext = 1'b1;
          if (extWe == 4'b0000) dmemDataNext = 32'hDEADBEEF;
        end
      end
      RESP: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (!I_rst) begin
      state    <= IDLE;
      dmemData <= 32'h0;
      busy     <= 1'b0;
      extReq   <= 1'b0;
      extAddr  <= 13'h0;
      extWData <= 32'h0;
      extWe    <= 4'h0;
      busError <= 1'b0;
      count    <= 8'd0;
    end else begin
      state    <= stateNext;
      dmemData <= dmemDataNext;
      busy     <= busyNext;
      extReq   <= extReqNext;
      extAddr  <= extAddrNext;
      extWData <= extWDataNext;
      extWe    <= extWeNext;
      busError <= busErrorNext;
      count    <= countNext;
    end
  end

  // RAM is deliberately left out of reset so contents survive it
  always_ff @(posedge I_clk) begin
    if (I_rst && ramWe) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.I_dmemWe[i]) ram[ramIdx][8*i +: 8] <= bus.I_dmemWData[8*i +: 8];
      end
    end
  end

  assign bus.O_dmemData = dmemData;
  assign bus.O_dmemBusy = busy;
  assign bus.O_extReq   = extReq;
  assign bus.O_extAddr  = extAddr;
  assign bus.O_extWData = extWData;
  assign bus.O_extWe    = extWe;
  assign bus.O_busError = busError;

endmodule

// File: tb/tb_ceespu_dmem_responder.sv
// Randomized scoreboard bench for ceespu_dmem_responder with a transaction-level reference model.
module tb_ceespu_dmem_responder;

  localparam int TMO = 4;

  logic I_clk = 1'b0;
  logic I_rst = 1'b0;
  always #5 I_clk = ~I_clk;

  ceespu_dmem_responder_if bus();

  ceespu_dmem_responder #(.RAM_AW(12), .TIMEOUT(TMO)) dut (
    .I_clk(I_clk),
    .I_rst(I_rst),
    .bus(bus)
  );

  typedef struct {
    bit          ext;
    logic [31:0] data;
    logic [12:0] extAddr;
    logic [31:0] extWData;
    logic [3:0]  extWe;
    int          waitCycles;
    logic        busErr;
  } exp_t;

  exp_t expQ[$];
  int compared = 0;
  int mismatched = 0;

  // reference model state
  logic [31:0] mem [int];
  logic [31:0] lastData = 32'h0;
  logic        modelErr = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // d = cycle of WAIT in which ack arrives (1..TMO), 0 = never ack
  task automatic issue(input logic [15:0] addr, input logic [31:0] wdata,
                       input logic [3:0] we, input int d, input logic [31:0] rdata);
    exp_t e;
    int   idx;
    logic [31:0] w;
    e.ext = addr[15];
    e.extAddr = addr[14:2];
    e.extWData = wdata;
    e.extWe = we;
    e.waitCycles = 0;
    if (addr[15]) begin
      e.waitCycles = (d >= 1 && d <= TMO) ? d : TMO;
      if (d >= 1 && d <= TMO) begin
        if (we == 4'b0000) lastData = rdata;
      end else begin
        if (we == 4'b0000) lastData = 32'hDEADBEEF;
        modelErr = 1'b1;
      end
    end else if (addr[14] == 1'b0) begin
      idx = int'(addr[13:2]);
      w = mem.exists(idx) ? mem[idx] : 32'h0;
      lastData = w;
      for (int i = 0; i < 4; i++) if (we[i]) w[8*i +: 8] = wdata[8*i +: 8];
      mem[idx] = w;
    end else begin
      if (we == 4'b0000) lastData = 32'h0;
    end
    e.data = lastData;
    e.busErr = modelErr;
    expQ.push_back(e);

    bus.I_dmemAddress = addr;
    bus.I_dmemWData = wdata;
    bus.I_dmemWe = we;
    bus.I_dmemE = 1'b1;
    @(posedge I_clk); #1;
    bus.I_dmemE = 1'b0;
    if (addr[15]) begin
      if (d >= 1 && d <= TMO) begin
        for (int i = 1; i <= d; i++) begin
          if (i == d) begin
            bus.I_extAck = 1'b1;
            bus.I_extRData = rdata;
          end
          @(posedge I_clk); #1;
          bus.I_extAck = 1'b0;
          bus.I_extRData = 32'h0;
        end
      end else begin
        repeat (TMO) begin @(posedge I_clk); #1; end
      end
      @(posedge I_clk); #1;
    end
  endtask

  // monitor: pops one expectation per accepted request and follows it to completion
  initial begin
    exp_t e;
    int   n;
    bit   busyBad;
    forever begin
      while (expQ.size() == 0) @(negedge I_clk);
      e = expQ.pop_front();
      @(negedge I_clk);
      if (!e.ext) begin
        check("intData", bus.O_dmemData, e.data);
        check("intBusy", {31'b0, bus.O_dmemBusy}, 32'h0);
        check("intBusErr", {31'b0, bus.O_busError}, {31'b0, e.busErr});
      end else begin
        check("extAddr", {19'b0, bus.O_extAddr}, {19'b0, e.extAddr});
        check("extWData", bus.O_extWData, e.extWData);
        check("extWe", {28'b0, bus.O_extWe}, {28'b0, e.extWe});
        n = 0;
        busyBad = 1'b0;
        while (bus.O_extReq === 1'b1 && n < 20) begin
          if (bus.O_dmemBusy !== 1'b1) busyBad = 1'b1;
          n++;
          @(negedge I_clk);
        end
        check("extReqCycles", n, e.waitCycles);
        check("busyInWait", {31'b0, busyBad}, 32'h0);
        check("respBusy", {31'b0, bus.O_dmemBusy}, 32'h0);
        check("respData", bus.O_dmemData, e.data);
        check("respBusErr", {31'b0, bus.O_busError}, {31'b0, e.busErr});
      end
    end
  end

  initial begin
    int kind, d;
    logic [15:0] a;
    logic [3:0]  we;
    bus.I_dmemAddress = 16'h0;
    bus.I_dmemWData = 32'h0;
    bus.I_dmemWe = 4'h0;
    bus.I_dmemE = 1'b0;
    bus.I_extAck = 1'b0;
    bus.I_extRData = 32'h0;
    repeat (3) @(posedge I_clk);
    @(negedge I_clk);
    check("rstBusy", {31'b0, bus.O_dmemBusy}, 32'h0);
    check("rstExtReq", {31'b0, bus.O_extReq}, 32'h0);
    check("rstBusErr", {31'b0, bus.O_busError}, 32'h0);
    check("rstExtWe", {28'b0, bus.O_extWe}, 32'h0);
    check("rstData", bus.O_dmemData, 32'h0);
    @(posedge I_clk); #1;
    I_rst = 1'b1;

    for (int i = 0; i < 16; i++) issue(16'(i * 4), $urandom, 4'hF, 0, 32'h0);

    // byte-lane merge then read back
    issue(16'h0010, 32'h12345678, 4'hF, 0, 32'h0);
    issue(16'h0010, 32'hABABABAB, 4'b0010, 0, 32'h0);
    issue(16'h0010, 32'h0, 4'h0, 0, 32'h0);
    if (mem[4] !== 32'h1234AB78) check("modelMerge", mem[4], 32'h1234AB78);

    // reserved region: reads zero, writes vanish
    issue(16'h0000, 32'h55AA33CC, 4'hF, 0, 32'h0);
    issue(16'h4000, 32'h0, 4'h0, 0, 32'h0);
    issue(16'h4000, 32'hFFFFFFFF, 4'hF, 0, 32'h0);
    issue(16'h0000, 32'h0, 4'h0, 0, 32'h0);

    issue(16'h8004, 32'h0, 4'h0, 3, 32'hCAFEF00D);
    issue(16'h8010, 32'h0, 4'h0, TMO, 32'h00000001);
    issue(16'h8008, 32'h77665544, 4'b1100, 0, 32'h0);
    issue(16'h0010, 32'h0, 4'h0, 0, 32'h0);
    issue(16'h800C, 32'h0, 4'h0, 2, 32'h13572468);

    for (int t = 0; t < 80; t++) begin
      kind = $urandom_range(0, 9);
      we = 4'($urandom);
      if (kind <= 3)
        issue(16'({$urandom_range(0, 15), 2'($urandom)}), $urandom, 4'h0, 0, 32'h0);
      else if (kind <= 5)
        issue(16'({$urandom_range(0, 15), 2'($urandom)}), $urandom, we, 0, 32'h0);
      else if (kind == 6)
        issue(16'h4000 | 16'($urandom_range(0, 16383)), $urandom, we, 0, 32'h0);
      else begin
        d = $urandom_range(0, TMO);
        issue(16'h8000 | 16'($urandom_range(0, 32767)), $urandom,
              ($urandom_range(0, 1) == 1) ? we : 4'h0, d, $urandom);
      end
    end

    // reset in the middle of an external wait
    bus.I_dmemAddress = 16'h8010;
    bus.I_dmemWe = 4'h0;
    bus.I_dmemE = 1'b1;
    @(posedge I_clk); #1;
    bus.I_dmemE = 1'b0;
    @(posedge I_clk); #1;
    I_rst = 1'b0;
    @(posedge I_clk);
    @(negedge I_clk);
    check("wrstExtReq", {31'b0, bus.O_extReq}, 32'h0);
    check("wrstBusy", {31'b0, bus.O_dmemBusy}, 32'h0);
    check("wrstBusErr", {31'b0, bus.O_busError}, 32'h0);
    check("wrstData", bus.O_dmemData, 32'h0);
    I_rst = 1'b1;
    lastData = 32'h0;
    modelErr = 1'b0;
    @(posedge I_clk); #1;
    issue(16'h0010, 32'h0, 4'h0, 0, 32'h0);
    issue(16'h0000, 32'h0, 4'h0, 0, 32'h0);

    repeat (4) @(negedge I_clk);
    if (expQ.size() != 0) check("queueDrained", expQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ceespu_dmem_responder.md
CEESPU_DMEM_RESPONDER -- requirements
Module: ceespu_dmem_responder

Interface
REQ-001 The block SHALL have one clock, I_clk; reset I_rst SHALL be synchronous and active-low.
REQ-002 Parameter RAM_AW, default 12, SHALL set the internal RAM word-address width (4096 x 32).
REQ-003 Parameter TIMEOUT, default 255, SHALL set the maximum external wait cycles before abort (8-bit counter).
REQ-004 I_clk  input  1  rising-edge clock.
REQ-005 I_rst  input  1  synchronous active-low reset.
REQ-006 I_dmemAddress  input  16  byte address from the CPU data port.
REQ-007 I_dmemWData  input  32  store data.
REQ-008 I_dmemE  input  1  access request strobe.
REQ-009 I_dmemWe  input  4  byte-lane write enables; 4'b0000 means read.
REQ-010 O_dmemData  output  32  registered read data.
REQ-011 O_dmemBusy  output  1  CPU stall request.
REQ-012 O_extReq  output  1  external SRAM request, level, held until ack.
REQ-013 O_extAddr  output  13  external word address.
REQ-014 O_extWData  output  32  external store data.
REQ-015 O_extWe  output  4  external byte-lane enables.
REQ-016 I_extAck  input  1  external completion, one cycle.
REQ-017 I_extRData  input  32  external read data, valid with I_extAck.
REQ-018 O_busError  output  1  sticky timeout flag.

Function
REQ-019 The block SHALL decode regions: addr[15:14]=00 internal RAM, word index addr[13:2]; addr[15]=1 external, O_extAddr=addr[14:2]; addr[15:14]=01 reserved; addr[1:0] SHALL be ignored.
REQ-020 An internal read accepted at edge k SHALL present the RAM word on O_dmemData after edge k, with no busy cycle.
REQ-021 An internal write SHALL update only the lanes with I_dmemWe bit set, at the accepting edge; lane i maps to bits [8i+7:8i].
REQ-022 An access carrying both read and write SHALL NOT occur; for a write, O_dmemData SHALL present the pre-write word (read-first).
REQ-023 A reserved-region read SHALL return 32'h0 after one cycle; a reserved-region write SHALL be discarded; neither SHALL assert busy.
REQ-024 The external FSM SHALL have states IDLE, WAIT, RESP; requests SHALL be accepted only in IDLE.
REQ-025 IDLE->WAIT on I_dmemE with addr[15]=1: address, data and lanes SHALL be latched to O_extAddr/O_extWData/O_extWe; O_extReq=1 and counter=0.
REQ-026 In WAIT, O_dmemBusy SHALL be 1 and O_extReq SHALL stay 1; the counter SHALL increment each cycle.
REQ-027 WAIT->RESP on I_extAck: read data SHALL be captured into O_dmemData; O_extReq SHALL drop at that edge.
REQ-028 WAIT->RESP when counter reaches TIMEOUT without ack: read data SHALL be 32'hDEADBEEF, O_busError SHALL set, O_extReq SHALL drop.
REQ-029 RESP SHALL last exactly one cycle with O_dmemBusy=0, then ->IDLE; I_dmemE in RESP SHALL be ignored.
REQ-030 O_dmemBusy SHALL be registered, asserted from the cycle after acceptance through the last WAIT cycle.
REQ-031 I_extAck outside WAIT SHALL be ignored.
REQ-032 I_dmemE while busy SHALL be ignored; the CPU holds its request stable.
REQ-033 O_dmemData SHALL hold its last value when no read completes.
REQ-034 Ack and timeout in the same cycle SHALL be resolved as ack, with O_busError unchanged.

Reset
REQ-035 With I_rst=0 at an edge: FSM=IDLE; O_dmemBusy, O_extReq and O_busError =0; O_extWe=0; O_dmemData=0; counter=0; RAM contents unchanged.
REQ-036 Reset in WAIT SHALL abandon the transfer: O_extReq=0 after that edge, with no RESP cycle.
REQ-037 O_busError SHALL clear only on reset.

Verification
REQ-038 Write 0x12345678 to 0x0010 with We=1111, then write 0xAB to 0x0010 with We=0010, then read 0x0010 -> O_dmemData=0x1234AB78 one cycle after the read, busy never 1.
REQ-039 External read of 0x8004 with ack after 3 cycles, I_extRData=0xCAFEF00D -> O_extAddr=0x0001; busy=1 for 3 cycles; RESP data 0xCAFEF00D; busError=0.
REQ-040 External write of 0x8008, We=1100, with no ack, TIMEOUT=4 -> O_extReq high for 4 cycles then drops; busError=1 and stays 1 through later good accesses.
REQ-041 Read of reserved 0x4000 -> O_dmemData=0 next cycle; write to 0x4000 -> internal word 0 unchanged.
REQ-042 Reset asserted 2 cycles into WAIT -> O_extReq=0 and busy=0 next cycle; a subsequent internal read works normally.
REQ-043 Ack arriving on the timeout cycle with data 0x1 -> O_dmemData=0x1 and busError=0.
